// File: rtl/food_pkg.sv
// rtl/food_pkg.sv - shared table constants, scheduler states and per-level placement masks
package food_pkg;
  localparam int POS_W       = 5;
  localparam int TABLE_DEPTH = 32;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CLEAR} state_t;

  // Every non-full level keeps bit 16 so at least one food can always be placed.
  function automatic logic [TABLE_DEPTH-1:0] LEVEL_MASK(input logic [3:0] level);
    case (level)
      4'd1:    return 32'hFFFF_FFFF;
      4'd2:    return 32'h5555_5555;
      4'd3:    return 32'h0F0F_0F0F;
      4'd4:    return 32'h00FF_FF00;
      4'd5:    return 32'h1111_1111;
      4'd6:    return 32'h8001_0001;
      4'd7:    return 32'hAAAB_0000;
      4'd8:    return 32'h0007_0000;
      4'd9:    return 32'h3333_3333;
      default: return 32'h0001_0000;
    endcase
  endfunction
endpackage

// File: rtl/food_slot_search.sv
// rtl/food_slot_search.sv - one-candidate-per-cycle placement search; FOOD_RESPAWN_RAND_EN seeds each search from an LFSR
module food_slot_search
  import food_pkg::*;
#(
  parameter int STRIDE = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic                   start,
  input  logic [TABLE_DEPTH-1:0] mask,
  input  logic [TABLE_DEPTH-1:0] occupied,
  output logic                   done,
  output logic                   found,
  output logic [POS_W-1:0]       pos
);
  logic             run;
  logic [5:0]       count;
  logic [POS_W-1:0] ptr;
  logic [POS_W-1:0] start_ptr;

  assign pos   = ptr;
  assign found = run && mask[ptr] && !occupied[ptr];
  assign done  = found || (run && count == 6'd31);

`ifdef FOOD_RESPAWN_RAND_EN
  logic [4:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 5'h01;
    else       lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
  end
  assign start_ptr = lfsr;
`else
  assign start_ptr = ptr;
`endif

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      run   <= 1'b0;
      count <= '0;
      ptr   <= '0;
    end else if (start) begin
      run   <= 1'b1;
      count <= '0;
      ptr   <= start_ptr;
    end else if (run) begin
      ptr   <= ptr + POS_W'(STRIDE);
      count <= count + 6'd1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/food_scheduler.sv
// rtl/food_scheduler.sv - food slot placement, eat arbitration, respawn timers and level clear; FOOD_RESPAWN_RAND_EN selects random search start
module food_scheduler
  import food_pkg::*;
#(
  parameter int N_SLOTS         = 4,
  parameter int FOODS_PER_LEVEL = 8,
  parameter int RESPAWN_FRAMES  = 30,
  parameter int STRIDE          = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     level_start,
  input  logic [3:0]               level,
  input  logic                     frame_tick,
  input  logic [N_SLOTS-1:0]       eat_req,
  output logic [N_SLOTS-1:0]       slot_active,
  output logic [N_SLOTS*POS_W-1:0] slot_pos,
  output logic [N_SLOTS-1:0]       eat_ack,
  output logic                     score_pulse,
  output logic [7:0]               foods_left,
  output logic                     level_clear,
  output logic                     busy
);
  localparam int IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int TMR_W = $clog2(RESPAWN_FRAMES + 1);
  localparam logic [7:0] FOODS = 8'(FOODS_PER_LEVEL);
  localparam logic [N_SLOTS-1:0] ONE = 1;

  state_t                 state;
  logic [TABLE_DEPTH-1:0] mask, occupied;
  logic [7:0]             spawned;
  logic [N_SLOTS-1:0]     pending, respawn_req, req_now, grant, expire, dispatch, act_set;
  logic [TMR_W-1:0]       timer [N_SLOTS];
  logic [IDX_W:0]         load_idx;
  logic [IDX_W-1:0]       tgt, rsp_idx;
  logic                   engaged, launch, restart, srch_restart, srch_done, srch_found, can_spawn;
  logic [POS_W-1:0]       srch_pos;

  assign can_spawn    = spawned < FOODS;
  assign restart      = level_start && (state == IDLE || state == RUN);
  assign srch_restart = restart || state == CLEAR;
  assign busy         = (state == LOAD) || engaged || (state == RUN && |respawn_req);

  always_comb begin
    occupied = '0;
    for (int i = 0; i < N_SLOTS; i++)
      if (slot_active[i]) occupied[slot_pos[i*POS_W +: POS_W]] = 1'b1;
    req_now = (state == RUN) ? (pending | (eat_req & slot_active)) : '0;
    grant   = req_now & (~req_now + ONE);
    rsp_idx = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (respawn_req[i]) rsp_idx = IDX_W'(i);
    dispatch = (state == RUN && !engaged) ? (respawn_req & (~respawn_req + ONE)) : '0;
    act_set  = '0;
    if (engaged && srch_done && srch_found) act_set[tgt] = 1'b1;
    for (int i = 0; i < N_SLOTS; i++)
      expire[i] = frame_tick && state == RUN && timer[i] == TMR_W'(1);
  end

  food_slot_search #(.STRIDE(STRIDE)) u_search (
    .clk      (clk),
    .reset    (reset),
    .restart  (srch_restart),
    .start    (launch),
    .mask     (mask),
    .occupied (occupied),
    .done     (srch_done),
    .found    (srch_found),
    .pos      (srch_pos)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mask        <= '0;
      spawned     <= '0;
      pending     <= '0;
      respawn_req <= '0;
      load_idx    <= '0;
      tgt         <= '0;
      engaged     <= 1'b0;
      launch      <= 1'b0;
      slot_active <= '0;
      slot_pos    <= '0;
      eat_ack     <= '0;
      score_pulse <= 1'b0;
      foods_left  <= '0;
      level_clear <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) timer[i] <= '0;
    end else begin
      launch      <= 1'b0;
      eat_ack     <= '0;
      score_pulse <= 1'b0;
      level_clear <= 1'b0;
      if (restart) begin
        state       <= LOAD;
        mask        <= LEVEL_MASK(level);
        spawned     <= '0;
        foods_left  <= FOODS;
        slot_active <= '0;
        slot_pos    <= '0;
        pending     <= '0;
        respawn_req <= '0;
        load_idx    <= '0;
        engaged     <= 1'b0;
        for (int i = 0; i < N_SLOTS; i++) timer[i] <= '0;
      end else begin
        slot_active <= (slot_active | act_set) & ~grant;
        if (engaged && srch_done) begin
          engaged <= 1'b0;
          if (srch_found) begin
            slot_pos[int'(tgt)*POS_W +: POS_W] <= srch_pos;
            spawned <= spawned + 8'd1;
          end
        end
        case (state)
          IDLE: ;
          LOAD: if (!engaged) begin
            if (load_idx < (IDX_W+1)'(N_SLOTS) && can_spawn) begin
              launch   <= 1'b1;
              engaged  <= 1'b1;
              tgt      <= load_idx[IDX_W-1:0];
              load_idx <= load_idx + 1'b1;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            pending     <= req_now & ~grant;
            respawn_req <= (respawn_req & ~dispatch) | expire;
            if (|dispatch && can_spawn) begin
              launch  <= 1'b1;
              engaged <= 1'b1;
              tgt     <= rsp_idx;
            end
            if (|grant) begin
              eat_ack     <= grant;
              score_pulse <= 1'b1;
              if (foods_left != 8'd0) foods_left <= foods_left - 8'd1;
              if (foods_left == 8'd1) begin
                state       <= CLEAR;
                level_clear <= 1'b1;
              end
            end
            // A freshly loaded timer takes precedence over a coincident frame tick.
            for (int i = 0; i < N_SLOTS; i++) begin
              if (grant[i] && can_spawn)
                timer[i] <= TMR_W'(RESPAWN_FRAMES);
              else if (frame_tick && timer[i] != '0)
                timer[i] <= timer[i] - TMR_W'(1);
            end
          end
          CLEAR: begin
            slot_active <= '0;
            pending     <= '0;
            respawn_req <= '0;
            engaged     <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) timer[i] <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_food_scheduler.sv
// tb/tb_food_scheduler.sv - self-checking bench for food_scheduler against a slot-level reference model
module tb_food_scheduler;
  localparam int N = 4, PW = 5, F = 8, RF = 30, ST = 3;

  logic          clk = 1'b0;
  logic          reset, level_start, frame_tick;
  logic [3:0]    level;
  logic [N-1:0]  eat_req;
  logic [N-1:0]  slot_active, eat_ack;
  logic [N*PW-1:0] slot_pos;
  logic          score_pulse, level_clear, busy;
  logic [7:0]    foods_left;

  int n_assert = 0, n_fail = 0, n_clear = 0;

  int        m_pos [N];
  bit        m_act [N];
  int        m_tmr [N];
  int        m_ptr, m_spawned, m_foods;
  bit [31:0] m_mask;

  food_scheduler #(.N_SLOTS(N), .FOODS_PER_LEVEL(F), .RESPAWN_FRAMES(RF), .STRIDE(ST)) dut (
    .clk(clk), .reset(reset), .level_start(level_start), .level(level),
    .frame_tick(frame_tick), .eat_req(eat_req), .slot_active(slot_active),
    .slot_pos(slot_pos), .eat_ack(eat_ack), .score_pulse(score_pulse),
    .foods_left(foods_left), .level_clear(level_clear), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic bit [31:0] lvl_mask(input int lv);
    if (lv == 1) return 32'hFFFF_FFFF;
    if (lv == 2) return 32'h5555_5555;
    return 32'h0001_0000;
  endfunction

  function automatic logic [N-1:0] exp_act();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  function automatic logic [N*PW-1:0] exp_pos();
    logic [N*PW-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = PW'(m_pos[i]);
    return v;
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_spawned = 0;
    for (int i = 0; i < N; i++) begin m_act[i] = 0; m_pos[i] = 0; m_tmr[i] = 0; end
  endtask

  // Walk the table by STRIDE from the shared pointer, at most 32 candidates.
  task automatic model_search(input int slot);
    bit [31:0] occ = '0;
    for (int i = 0; i < N; i++) if (m_act[i]) occ[m_pos[i]] = 1'b1;
    for (int k = 0; k < 32; k++) begin
      int c = m_ptr;
      m_ptr = (m_ptr + ST) % 32;
      if (m_mask[c] && !occ[c]) begin
        m_act[slot] = 1; m_pos[slot] = c; m_spawned++;
        return;
      end
    end
  endtask

  task automatic check_slots(input string tag);
    chk({tag, "_active"}, slot_active, exp_act());
    chk({tag, "_pos"}, slot_pos, exp_pos());
    chk({tag, "_foods"}, foods_left, m_foods);
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 500) begin step(); c++; end
    chk({tag, "_busy_timeout"}, busy, 0);
  endtask

  task automatic start_level(input int lv);
    level = 4'(lv); level_start = 1; step(); level_start = 0;
    chk("busy_load", busy, 1);
    model_clear();
    m_mask = lvl_mask(lv); m_foods = F;
    for (int s = 0; s < N; s++) if (m_spawned < F) model_search(s);
    wait_idle("load");
    check_slots("load");
  endtask

  task automatic do_eat(input logic [N-1:0] vec);
    logic [N-1:0] want = vec & exp_act();
    eat_req = vec; step(); eat_req = '0;
    for (int i = 0; i < N; i++) begin
      if (want[i] && m_foods > 0) begin
        chk("eat_ack", eat_ack, N'(1) << i);
        chk("score_pulse", score_pulse, 1);
        m_act[i] = 0; m_foods--;
        if (m_spawned < F) m_tmr[i] = RF;
        if (level_clear) n_clear++;
        chk("level_clear", level_clear, m_foods == 0);
        step();
      end
    end
    if (m_foods == 0) for (int i = 0; i < N; i++) begin m_act[i] = 0; m_tmr[i] = 0; end
    chk("eat_ack_idle", eat_ack, 0);
    chk("score_idle", score_pulse, 0);
    check_slots("eat");
  endtask

  task automatic tick();
    bit expd [N];
    bit any = 0;
    frame_tick = 1; step(); frame_tick = 0;
    for (int i = 0; i < N; i++) begin
      expd[i] = 0;
      if (m_tmr[i] > 0) begin
        m_tmr[i]--;
        if (m_tmr[i] == 0) begin expd[i] = 1; any = 1; end
      end
    end
    if (any) begin
      chk("busy_respawn", busy, 1);
      wait_idle("respawn");
      for (int i = 0; i < N; i++) if (expd[i] && m_spawned < F) model_search(i);
      check_slots("respawn");
    end
  endtask

  initial begin
    reset = 1; level_start = 0; frame_tick = 0; level = '0; eat_req = '0;
    step(); step();
    chk("rst_active", slot_active, 0);
    chk("rst_pos", slot_pos, 0);
    chk("rst_misc", {eat_ack, score_pulse, foods_left, level_clear, busy}, 0);
    reset = 0;
    model_clear(); m_foods = 0;
    step();

    start_level(1);
    chk("t1_pos_literal", slot_pos, {5'd9, 5'd6, 5'd3, 5'd0});
    do_eat(4'b0101);
    chk("t3_foods", foods_left, 6);
    repeat (RF) tick();
    chk("t4_pos0", slot_pos[4:0], 5'd12);
    chk("t4_spawned", m_spawned, 6);

    for (int it = 0; it < 60 && m_foods > 0; it++) begin
      if (exp_act() == '0 || $urandom_range(0, 2) == 0) repeat (RF) tick();
      else do_eat(N'($urandom_range(1, 15)));
    end
    chk("t5_foods_zero", foods_left, 0);
    chk("t5_clear_once", n_clear, 1);
    eat_req = '1; step(); step(); eat_req = '0;
    chk("idle_no_ack", eat_ack, 0);
    chk("no_underflow", foods_left, 0);

    start_level(0);
    chk("t2_active", slot_active, 4'b0001);
    chk("t2_pos0", slot_pos[4:0], 5'd16);

    start_level(2);
    do_eat(4'b0001);
    repeat (RF - 1) tick();
    frame_tick = 1; step(); frame_tick = 0;
    chk("t6_busy_before_reset", busy, 1);
    step();
    reset = 1; step(); reset = 0;
    model_clear(); m_foods = 0;
    chk("t6_rst_active", slot_active, 0);
    chk("t6_rst_pos", slot_pos, 0);
    chk("t6_rst_misc", {eat_ack, score_pulse, foods_left, level_clear, busy}, 0);
    step();
    chk("t6_rst_idle", busy, 0);
    start_level(1);
    chk("t6_reload_pos", slot_pos, {5'd9, 5'd6, 5'd3, 5'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
